// File: rtl/qconv_pkg.sv
// Shared definitions for the qconv output writer: FSM encoding, output bit width,
// threshold count and the bit-plane packing order.
package qconv_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_FLUSH = ST_FLUSH,
        S_DONE  = ST_DONE
    } state_e;

    localparam int OUT_BIT_WIDTH = 2;
    localparam int NUM_TH        = 3;

    // Bit b of channel ch lands in plane b: planes are OC_UNROLL bits wide, plane 0 lowest.
    function automatic int plane_bit(input int ch, input int bit_idx, input int oc_unroll);
        return bit_idx * oc_unroll + ch;
    endfunction

endpackage

// File: rtl/qconv_out_quantize.sv
// Per-channel quantizer: signed accumulator -> 2-bit code. Shift-and-clamp by default,
// three-threshold compare when QCONV_OUTPUT_THRESHOLD_EN is defined.
module qconv_out_quantize
    import qconv_pkg::*;
#(
    parameter int ACC_WIDTH = 16,
    parameter int SHIFT     = 4
) (
    input  logic [ACC_WIDTH-1:0]        acc_i,
`ifdef QCONV_OUTPUT_THRESHOLD_EN
    input  logic [NUM_TH*ACC_WIDTH-1:0] th_i,
`endif
    output logic [OUT_BIT_WIDTH-1:0]    q_o
);

`ifdef QCONV_OUTPUT_THRESHOLD_EN
    logic [NUM_TH-1:0] ge_w;

    always_comb begin
        for (int k = 0; k < NUM_TH; k++) begin
            ge_w[k] = $signed(acc_i) >= $signed(th_i[k*ACC_WIDTH +: ACC_WIDTH]);
        end
    end

    assign q_o = {1'b0, ge_w[0]} + {1'b0, ge_w[1]} + {1'b0, ge_w[2]};
`else
    localparam logic signed [ACC_WIDTH-1:0] Q_MAX = 3;
    logic signed [ACC_WIDTH-1:0] sh_w;

    assign sh_w = $signed(acc_i) >>> SHIFT;

    always_comb begin
        if (sh_w[ACC_WIDTH-1]) begin
            q_o = '0;
        end else if (sh_w > Q_MAX) begin
            q_o = 2'd3;
        end else begin
            q_o = sh_w[1:0];
        end
    end
`endif

endmodule

// File: rtl/qconv_output_writer.sv
// Output writer for the kn2row WRITE_OUTPUT stream: quantize, pack into bit-planes,
// issue one write per beat. Optional threshold quantizer: QCONV_OUTPUT_THRESHOLD_EN.
module qconv_output_writer
    import qconv_pkg::*;
#(
    parameter int OC_UNROLL  = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int BIT_WIDTH  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DIM_WIDTH  = 16,
    parameter int SHIFT      = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic [DIM_WIDTH-1:0]              cfg_out_w,
    input  logic [DIM_WIDTH-1:0]              cfg_out_h,
    input  logic [DIM_WIDTH-1:0]              cfg_oc_groups,
    input  logic [ADDR_WIDTH-1:0]             cfg_base,
    output logic                              busy,
    output logic                              done,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [OC_UNROLL*ACC_WIDTH-1:0]    in_acc,
`ifdef QCONV_OUTPUT_THRESHOLD_EN
    input  logic [OC_UNROLL*3*ACC_WIDTH-1:0]  in_th,
`endif
    output logic                              wr_valid,
    input  logic                              wr_ready,
    output logic [ADDR_WIDTH-1:0]             wr_addr,
    output logic [OC_UNROLL*BIT_WIDTH-1:0]    wr_data
);

    state_e                         state_q, state_d;
    logic [DIM_WIDTH-1:0]           w_q, w_d, h_q, h_d, groups_q, groups_d;
    logic [DIM_WIDTH-1:0]           x_q, x_d, y_q, y_d, g_q, g_d;
    logic [ADDR_WIDTH-1:0]          ptr_q, ptr_d, row_q, row_d;
    logic                           wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0]          wr_addr_q, wr_addr_d;
    logic [OC_UNROLL*BIT_WIDTH-1:0] wr_data_q, wr_data_d;

    logic [OUT_BIT_WIDTH-1:0]       q_w [OC_UNROLL];
    logic [OC_UNROLL*BIT_WIDTH-1:0] packed_w;
    logic                           accept_w, x_end_w, y_end_w, g_end_w;
    logic [ADDR_WIDTH-1:0]          stride_w;

    for (genvar i = 0; i < OC_UNROLL; i++) begin : g_quant
        qconv_out_quantize #(
            .ACC_WIDTH(ACC_WIDTH),
            .SHIFT    (SHIFT)
        ) u_quant (
            .acc_i(in_acc[i*ACC_WIDTH +: ACC_WIDTH]),
`ifdef QCONV_OUTPUT_THRESHOLD_EN
            .th_i (in_th[i*NUM_TH*ACC_WIDTH +: NUM_TH*ACC_WIDTH]),
`endif
            .q_o  (q_w[i])
        );
    end

    always_comb begin
        packed_w = '0;
        for (int i = 0; i < OC_UNROLL; i++) begin
            for (int b = 0; b < BIT_WIDTH; b++) begin
                packed_w[plane_bit(i, b, OC_UNROLL)] = q_w[i][b];
            end
        end
    end

    // A new beat may enter only when the output register is empty or draining this cycle.
    assign in_ready = (state_q == S_RUN) && (!wr_valid_q || wr_ready);
    assign accept_w = in_valid && in_ready;
    assign x_end_w  = (x_q == w_q - DIM_WIDTH'(1));
    assign y_end_w  = (y_q == h_q - DIM_WIDTH'(1));
    assign g_end_w  = (g_q == groups_q - DIM_WIDTH'(1));
    assign stride_w = ADDR_WIDTH'(groups_q);

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        groups_d   = groups_q;
        x_d        = x_q;
        y_d        = y_q;
        g_d        = g_q;
        ptr_d      = ptr_q;
        row_d      = row_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_d      = cfg_out_w;
                    h_d      = cfg_out_h;
                    groups_d = cfg_oc_groups;
                    x_d      = '0;
                    y_d      = '0;
                    g_d      = '0;
                    ptr_d    = cfg_base;
                    row_d    = cfg_base;
                    if (cfg_out_w == '0 || cfg_out_h == '0 || cfg_oc_groups == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (accept_w) begin
                    if (x_end_w) begin
                        x_d = '0;
                        if (y_end_w) begin
                            // Next channel group restarts one word past the previous group's first pixel.
                            y_d   = '0;
                            g_d   = g_q + DIM_WIDTH'(1);
                            row_d = row_q + ADDR_WIDTH'(1);
                            ptr_d = row_q + ADDR_WIDTH'(1);
                            if (g_end_w) begin
                                state_d = S_FLUSH;
                            end
                        end else begin
                            y_d   = y_q + DIM_WIDTH'(1);
                            ptr_d = ptr_q + stride_w;
                        end
                    end else begin
                        x_d   = x_q + DIM_WIDTH'(1);
                        ptr_d = ptr_q + stride_w;
                    end
                end
            end
            S_FLUSH: begin
                if (!wr_valid_q || wr_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept_w) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = packed_w;
        end else if (wr_ready) begin
            wr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            w_q        <= '0;
            h_q        <= '0;
            groups_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            g_q        <= '0;
            ptr_q      <= '0;
            row_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            groups_q   <= groups_d;
            x_q        <= x_d;
            y_q        <= y_d;
            g_q        <= g_d;
            ptr_q      <= ptr_d;
            row_q      <= row_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_qconv_output_writer.sv
// Testbench for qconv_output_writer: directed frames plus randomized frames checked
// against a loop-order/quantization reference model.
module tb_qconv_output_writer;

    localparam int OC   = 8;
    localparam int ACCW = 16;
    localparam int BW   = 2;
    localparam int ADW  = 32;
    localparam int DW   = 16;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic [DW-1:0]        cfg_out_w = '0;
    logic [DW-1:0]        cfg_out_h = '0;
    logic [DW-1:0]        cfg_oc_groups = '0;
    logic [ADW-1:0]       cfg_base = '0;
    logic                 busy, done;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [OC*ACCW-1:0]   in_acc = '0;
`ifdef QCONV_OUTPUT_THRESHOLD_EN
    logic [OC*3*ACCW-1:0] in_th;
`endif
    logic                 wr_valid;
    logic                 wr_ready = 1'b0;
    logic [ADW-1:0]       wr_addr;
    logic [OC*BW-1:0]     wr_data;

    int total = 0;
    int bad   = 0;
    logic [ADW+OC*BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    qconv_output_writer dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .cfg_out_w    (cfg_out_w),
        .cfg_out_h    (cfg_out_h),
        .cfg_oc_groups(cfg_oc_groups),
        .cfg_base     (cfg_base),
        .busy         (busy),
        .done         (done),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_acc       (in_acc),
`ifdef QCONV_OUTPUT_THRESHOLD_EN
        .in_th        (in_th),
`endif
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

`ifdef QCONV_OUTPUT_THRESHOLD_EN
    initial begin
        for (int i = 0; i < OC; i++) begin
            in_th[(3*i+0)*ACCW +: ACCW] = 16'sd10;
            in_th[(3*i+1)*ACCW +: ACCW] = 16'sd20;
            in_th[(3*i+2)*ACCW +: ACCW] = 16'sd30;
        end
    end
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int q_of(input int a);
`ifdef QCONV_OUTPUT_THRESHOLD_EN
        return int'(a >= 10) + int'(a >= 20) + int'(a >= 30);
`else
        if (a < 16) return 0;
        if (a >= 64) return 3;
        return a / 16;
`endif
    endfunction

    function automatic logic [OC*BW-1:0] model_data(input logic [OC*ACCW-1:0] acc);
        logic [OC*BW-1:0] d;
        int qv;
        d = '0;
        for (int i = 0; i < OC; i++) begin
            qv = q_of(int'($signed(acc[i*ACCW +: ACCW])));
            d[i]      = qv[0];
            d[OC + i] = qv[1];
        end
        return d;
    endfunction

    // Beat n in producer order: x fastest, then y, then channel group.
    function automatic logic [ADW-1:0] model_addr(input int n, input int w, input int h,
                                                  input int g, input logic [ADW-1:0] base);
        int x, y, gg;
        x  = n % w;
        y  = (n / w) % h;
        gg = n / (w * h);
        return base + ADW'((y * w + x) * g + gg);
    endfunction

    function automatic logic [OC*ACCW-1:0] rand_acc();
        logic [OC*ACCW-1:0] a;
        for (int i = 0; i < OC; i++) begin
            a[i*ACCW +: ACCW] = ACCW'(int'($urandom_range(0, 500)) - 150);
        end
        return a;
    endfunction

    function automatic logic [OC*ACCW-1:0] directed_acc();
        logic [OC*ACCW-1:0] a;
`ifdef QCONV_OUTPUT_THRESHOLD_EN
        for (int i = 0; i < OC; i++) a[i*ACCW +: ACCW] = 16'sd5;
        a[0*ACCW +: ACCW] = 16'sd9;
        a[1*ACCW +: ACCW] = 16'sd10;
        a[2*ACCW +: ACCW] = 16'sd25;
        a[3*ACCW +: ACCW] = 16'sd30;
`else
        for (int i = 0; i < OC; i++) a[i*ACCW +: ACCW] = 16'sd16;
        a[0*ACCW +: ACCW] = 16'sd37;
        a[1*ACCW +: ACCW] = -16'sd5;
        a[7*ACCW +: ACCW] = 16'sd200;
`endif
        return a;
    endfunction

    // rdy_mode: 0 = always ready, 1 = five-cycle stall early in the frame, 2 = random.
    task automatic run_frame(input int w, input int h, input int g, input logic [ADW-1:0] base,
                             input int rdy_mode, input bit directed, input int abort_after);
        int nbeats, sent, got, cyc, last_pop;
        bit finished, stalled, first_pop;
        logic [ADW-1:0] held_a;
        logic [OC*BW-1:0] held_d;
        logic [ADW+OC*BW-1:0] e;
        nbeats = w * h * g;
        sent = 0; got = 0; cyc = 0; last_pop = -10;
        finished = 0; stalled = 0; first_pop = 1;
        held_a = '0; held_d = '0;
        exp_q.delete();

        @(negedge clk);
        cfg_out_w = DW'(w); cfg_out_h = DW'(h); cfg_oc_groups = DW'(g); cfg_base = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);

        while (!finished && cyc < 2000) begin
            if (stalled) begin
                chk("stall_addr_stable", 64'(wr_addr), 64'(held_a));
                chk("stall_data_stable", 64'(wr_data), 64'(held_d));
            end
            if (done) begin
                chk("done_timing", 64'(cyc), 64'(last_pop + 1));
                chk("beats_written", 64'(got), 64'(nbeats));
                finished = 1;
            end else begin
                case (rdy_mode)
                    0:       wr_ready = 1'b1;
                    1:       wr_ready = !(cyc >= 4 && cyc < 9);
                    default: wr_ready = ($urandom_range(0, 3) != 0);
                endcase
                in_valid = (sent < nbeats) && (rdy_mode != 2 || $urandom_range(0, 2) != 0);
                start    = (rdy_mode == 2 && sent < nbeats) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_acc   = (directed && sent == 0) ? directed_acc() : rand_acc();
                #1;
                if (wr_valid && !wr_ready) chk("in_ready_blocked", 64'(in_ready), 64'd0);
                if (rdy_mode != 2 && sent < nbeats && wr_ready)
                    chk("in_ready_throughput", 64'(in_ready), 64'd1);
                if (wr_valid && wr_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_write", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 64'(wr_addr), 64'(e[ADW+OC*BW-1:OC*BW]));
                        chk("wr_data", 64'(wr_data), 64'(e[OC*BW-1:0]));
                        if (directed && first_pop) begin
`ifdef QCONV_OUTPUT_THRESHOLD_EN
                            chk("quant_example", 64'(wr_data), 64'h0C0A);
`else
                            chk("quant_example", 64'(wr_data), 64'h81FC);
`endif
                        end
                        first_pop = 0;
                    end
                    got++;
                    last_pop = cyc;
                end
                stalled = wr_valid && !wr_ready;
                held_a  = wr_addr;
                held_d  = wr_data;
                if (in_valid && in_ready) begin
                    exp_q.push_back({model_addr(sent, w, h, g, base), model_data(in_acc)});
                    sent++;
                    if (abort_after != 0 && sent == abort_after) begin
                        rstn = 1'b0;
                        @(negedge clk);
                        chk("abort_wr_valid", 64'(wr_valid), 64'd0);
                        chk("abort_busy", 64'(busy), 64'd0);
                        chk("abort_done", 64'(done), 64'd0);
                        rstn = 1'b1;
                        in_valid = 1'b0;
                        start = 1'b0;
                        repeat (3) begin
                            @(negedge clk);
                            chk("abort_no_done", 64'(done), 64'd0);
                        end
                        exp_q.delete();
                        return;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk("frame_finished", 64'(finished), 64'd1);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic run_zero(input int w, input int h, input int g);
        @(negedge clk);
        cfg_out_w = DW'(w); cfg_out_h = DW'(h); cfg_oc_groups = DW'(g); cfg_base = 32'h40;
        wr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_busy", 64'(busy), 64'd1);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_no_write", 64'(wr_valid), 64'd0);
        @(negedge clk);
        chk("zero_busy_low", 64'(busy), 64'd0);
        chk("zero_done_low", 64'(done), 64'd0);
        chk("zero_no_write2", 64'(wr_valid), 64'd0);
    endtask

    initial begin
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        rstn = 1'b1;

        run_frame(2, 2, 3, 32'h100, 0, 1'b1, 0);
        run_frame(2, 2, 3, 32'h100, 1, 1'b0, 0);
        run_zero(2, 0, 3);
        run_zero(0, 2, 3);
        run_zero(2, 2, 0);
        run_frame(2, 2, 3, 32'h200, 0, 1'b0, 5);
        run_frame(2, 2, 3, 32'h200, 0, 1'b0, 0);
        run_frame(1, 1, 1, 32'h7, 0, 1'b1, 0);
        run_frame(3, 2, 2, 32'hFFFF_FFFA, 2, 1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                      int'($urandom_range(1, 3)), ADW'($urandom), 2, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
